// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts {opcode, arg} words over valid/ready and drives
// registered ALU control strobes for single- and multi-cycle operations.
module instr_sequencer #(
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    ARG_WIDTH    = 8,
  parameter int                    NUM_REGS     = 5,
  parameter int                    MAC_LATENCY  = 3,
  parameter logic [NUM_REGS-1:0]   RES_MASK     = 5'b00101
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              instr_valid,
  input  logic [OPCODE_WIDTH+ARG_WIDTH-1:0] instr,
  output logic                              instr_ready,
  output logic                              f_add,
  output logic                              f_mac,
  output logic                              f_wait,
  output logic                              wr_res,
  output logic [NUM_REGS-1:0]               alu_reg_en,
  output logic                              busy,
  output logic                              illegal_op
);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_MAC  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_WAIT = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SETR = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(4);
  localparam logic [ARG_WIDTH-1:0]    CNT_ONE = ARG_WIDTH'(1);
  localparam logic [ARG_WIDTH-1:0]    MAC_D   = ARG_WIDTH'(MAC_LATENCY);
  localparam logic [31:0]             NREGS_U = 32'(NUM_REGS);

  state_t                   state_q, state_d;
  logic [ARG_WIDTH-1:0]     cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0]  op_q, op_d;
  logic [ARG_WIDTH-1:0]     arg_q, arg_d;

  logic                     f_add_q, f_add_d;
  logic                     f_mac_q, f_mac_d;
  logic                     f_wait_q, f_wait_d;
  logic                     wr_res_q, wr_res_d;
  logic [NUM_REGS-1:0]      alu_reg_en_q, alu_reg_en_d;
  logic                     busy_q, busy_d;
  logic                     illegal_op_q, illegal_op_d;

  logic [OPCODE_WIDTH-1:0]  in_op;
  logic [ARG_WIDTH-1:0]     in_arg;
  logic [ARG_WIDTH-1:0]     in_dur;
  logic                     accept;
  logic                     exec_d;
  logic                     last_d;
  logic                     op_legal_d;
  logic                     arg_in_range_d;
  logic [NUM_REGS-1:0]      setr_hot_d;

  assign in_op  = instr[OPCODE_WIDTH+ARG_WIDTH-1:ARG_WIDTH];
  assign in_arg = instr[ARG_WIDTH-1:0];

  // Ready in idle, or in the final cycle of an op so the next issues without a bubble.
  assign instr_ready = (state_q == S_IDLE) || (cnt_q == CNT_ONE);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    in_dur = CNT_ONE;
    case (in_op)
      OP_MAC:  in_dur = MAC_D;
      OP_WAIT: in_dur = (in_arg == '0) ? CNT_ONE : in_arg;
      default: in_dur = CNT_ONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    arg_d   = arg_q;
    if (accept) begin
      state_d = S_EXEC;
      cnt_d   = in_dur;
      op_d    = in_op;
      arg_d   = in_arg;
    end else if (state_q == S_EXEC) begin
      if (cnt_q <= CNT_ONE) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // One-hot register select for SETR, one comparator per register.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_setr_hot
      assign setr_hot_d[gi] = (arg_d == ARG_WIDTH'(gi));
    end
  endgenerate

  assign exec_d         = (state_d == S_EXEC);
  assign last_d         = (cnt_d == CNT_ONE);
  assign arg_in_range_d = (32'(arg_d) < NREGS_U);
  assign op_legal_d     = (op_d == OP_ADD) || (op_d == OP_MAC) || (op_d == OP_WAIT) ||
                          (op_d == OP_SETR) || (op_d == OP_NOP);

  // Outputs are decoded from the next state so they appear registered in the op's cycles.
  always_comb begin
    f_add_d      = 1'b0;
    f_mac_d      = 1'b0;
    f_wait_d     = 1'b0;
    wr_res_d     = 1'b0;
    alu_reg_en_d = '0;
    busy_d       = exec_d;
    illegal_op_d = 1'b0;
    if (exec_d) begin
      if (!op_legal_d) begin
        illegal_op_d = 1'b1;
      end else begin
        case (op_d)
          OP_ADD: begin
            f_add_d      = 1'b1;
            wr_res_d     = 1'b1;
            alu_reg_en_d = RES_MASK;
          end
          OP_MAC: begin
            f_mac_d = 1'b1;
            if (last_d) begin
              wr_res_d     = 1'b1;
              alu_reg_en_d = RES_MASK;
            end
          end
          OP_WAIT: f_wait_d = 1'b1;
          OP_SETR: begin
            if (arg_in_range_d) begin
              alu_reg_en_d = setr_hot_d;
            end else begin
              illegal_op_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      arg_q        <= '0;
      f_add_q      <= 1'b0;
      f_mac_q      <= 1'b0;
      f_wait_q     <= 1'b0;
      wr_res_q     <= 1'b0;
      alu_reg_en_q <= '0;
      busy_q       <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      f_add_q      <= f_add_d;
      f_mac_q      <= f_mac_d;
      f_wait_q     <= f_wait_d;
      wr_res_q     <= wr_res_d;
      alu_reg_en_q <= alu_reg_en_d;
      busy_q       <= busy_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign f_add      = f_add_q;
  assign f_mac      = f_mac_q;
  assign f_wait     = f_wait_q;
  assign wr_res     = wr_res_q;
  assign alu_reg_en = alu_reg_en_q;
  assign busy       = busy_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed vector table, reset-mid-MAC sequence and a random stream checked
// against a small cycle model of the sequencer.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [10:0] instr;
  logic        instr_ready;
  logic        f_add, f_mac, f_wait, wr_res, busy, illegal_op;
  logic [4:0]  alu_reg_en;

  int ntests = 0;
  int nfail  = 0;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .f_add(f_add), .f_mac(f_mac), .f_wait(f_wait),
    .wr_res(wr_res), .alu_reg_en(alu_reg_en), .busy(busy), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [7:0]  arg;
    logic        rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t tv[$];

  // Packing order: {f_add, f_mac, f_wait, wr_res, alu_reg_en[4:0], busy, illegal_op}
  function automatic logic [10:0] ex(input logic a, input logic m, input logic w,
                                     input logic wr, input logic [4:0] en,
                                     input logic b, input logic il);
    return {a, m, w, wr, en, b, il};
  endfunction

  function automatic logic [10:0] obs();
    return {f_add, f_mac, f_wait, wr_res, alu_reg_en, busy, illegal_op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [7:0] arg,
                      output logic rdy_before);
    instr_valid = v;
    instr       = {op, arg};
    #1;
    rdy_before = instr_ready;
    @(posedge clk);
    #1;
  endtask

  logic [10:0] Z, ADDO, MAC1, MACL, WAITO, BUSYO;
  logic        r;

  // Reference model state
  int          mrem, mop, marg, md;
  int          hs, done;
  logic [10:0] mexp;
  logic [4:0]  men;

  initial begin
    Z     = ex(0,0,0,0,5'b00000,0,0);
    ADDO  = ex(1,0,0,1,5'b00101,1,0);
    MAC1  = ex(0,1,0,0,5'b00000,1,0);
    MACL  = ex(0,1,0,1,5'b00101,1,0);
    WAITO = ex(0,0,1,0,5'b00000,1,0);
    BUSYO = ex(0,0,0,0,5'b00000,1,0);

    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b1, ADDO});    // ADD
    tv.push_back('{1'b0, 3'd0, 8'd0, 1'b1, Z});
    tv.push_back('{1'b1, 3'd1, 8'd0, 1'b1, MAC1});    // MAC
    tv.push_back('{1'b0, 3'd0, 8'd0, 1'b0, MAC1});
    tv.push_back('{1'b0, 3'd0, 8'd0, 1'b0, MACL});
    tv.push_back('{1'b0, 3'd0, 8'd0, 1'b1, Z});
    tv.push_back('{1'b1, 3'd2, 8'd5, 1'b1, WAITO});   // WAIT 5, ADD held
    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b0, WAITO});
    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b0, WAITO});
    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b0, WAITO});
    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b0, WAITO});
    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b1, ADDO});
    tv.push_back('{1'b1, 3'd2, 8'd0, 1'b1, WAITO});   // WAIT 0 -> 1 cycle
    tv.push_back('{1'b1, 3'd3, 8'd3, 1'b1, ex(0,0,0,0,5'b01000,1,0)});
    tv.push_back('{1'b1, 3'd3, 8'd7, 1'b1, ex(0,0,0,0,5'b00000,1,1)});
    tv.push_back('{1'b1, 3'd6, 8'd0, 1'b1, ex(0,0,0,0,5'b00000,1,1)});
    tv.push_back('{1'b1, 3'd4, 8'd0, 1'b1, BUSYO});   // NOP
    tv.push_back('{1'b1, 3'd1, 8'd0, 1'b1, MAC1});    // MAC, instr changes ignored
    tv.push_back('{1'b1, 3'd3, 8'd0, 1'b0, MAC1});
    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b0, MACL});
    tv.push_back('{1'b1, 3'd0, 8'd0, 1'b1, ADDO});
    tv.push_back('{1'b1, 3'd3, 8'd4, 1'b1, ex(0,0,0,0,5'b10000,1,0)});
    tv.push_back('{1'b1, 3'd3, 8'd5, 1'b1, ex(0,0,0,0,5'b00000,1,1)});
    tv.push_back('{1'b1, 3'd2, 8'd1, 1'b1, WAITO});
    tv.push_back('{1'b1, 3'd7, 8'd9, 1'b1, ex(0,0,0,0,5'b00000,1,1)});
    tv.push_back('{1'b0, 3'd0, 8'd0, 1'b1, Z});

    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs()), 32'(Z));
    #2 rst_n = 1'b1;
    #1;
    chk("reset_ready", 32'(instr_ready), 32'd1);

    foreach (tv[i]) begin
      step(tv[i].v, tv[i].op, tv[i].arg, r);
      chk($sformatf("vec%0d_ready", i), 32'(r), 32'(tv[i].rdy));
      chk($sformatf("vec%0d_out", i), 32'(obs()), 32'(tv[i].exp));
      $display("[TB] vec %0d v=%0d op=%0d arg=%0d ready=%0d out=%b", i, tv[i].v,
               tv[i].op, tv[i].arg, r, obs());
    end

    // Reset asserted during the second MAC cycle
    step(1'b1, 3'd1, 8'd0, r);
    chk("rmac_c1", 32'(obs()), 32'(MAC1));
    step(1'b0, 3'd0, 8'd0, r);
    chk("rmac_c2", 32'(obs()), 32'(MAC1));
    #2 rst_n = 1'b0;
    #1;
    chk("rmac_async_clear", 32'(obs()), 32'(Z));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rmac_hold%0d", k), 32'({wr_res, busy, f_mac}), 32'd0);
    end
    #2 rst_n = 1'b1;
    #1;
    chk("rmac_ready_after", 32'(instr_ready), 32'd1);
    step(1'b1, 3'd0, 8'd0, r);
    chk("rmac_add_out", 32'(obs()), 32'(ADDO));
    step(1'b0, 3'd0, 8'd0, r);
    chk("rmac_idle", 32'(obs()), 32'(Z));
    $display("[TB] reset-mid-MAC sequence done");

    // Random stream against a cycle model
    mrem = 0; mop = 0; marg = 0; hs = 0; done = 0;
    for (int c = 0; c < 400; c++) begin
      logic       v;
      logic [2:0] op;
      logic [7:0] arg;
      logic       mready, acc;
      v   = ($urandom_range(0, 9) < 7);
      op  = 3'($urandom_range(0, 7));
      arg = (op == 3'd2) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 7));
      if (c >= 380) v = 1'b0;   // drain
      mready = (mrem <= 1);
      acc = v && mready;
      step(v, op, arg, r);
      chk("rnd_ready", 32'(r), 32'(mready));
      if (acc) begin
        hs++;
        mop = op; marg = arg;
        md = (op == 3'd1) ? 3 : (op == 3'd2) ? ((arg == 0) ? 1 : int'(arg)) : 1;
        mrem = md;
      end else if (mrem > 0) begin
        mrem--;
      end
      men = 5'b00000;
      if (mrem > 0) begin
        if (mop == 0 || (mop == 1 && mrem == 1)) men = 5'b00101;
        else if (mop == 3 && marg < 5) men = 5'(1 << marg);
        mexp = ex(mop == 0, mop == 1, mop == 2, mop == 0 || (mop == 1 && mrem == 1),
                  men, 1'b1, mop >= 5 || (mop == 3 && marg >= 5));
      end else begin
        mexp = Z;
      end
      chk($sformatf("rnd%0d_out", c), 32'(obs()), 32'(mexp));
      chk("rnd_onehot", 32'($countones({f_add, f_mac, f_wait}) <= 1), 32'd1);
      if (busy && instr_ready) done++;
      $display("[TB] rnd %0d v=%0d op=%0d arg=%0d acc=%0d out=%b", c, v, op, arg, acc, obs());
    end
    chk("rnd_handshakes_vs_completed", 32'(done), 32'(hs));
    chk("rnd_final_idle", 32'({busy, instr_ready}), 32'b01);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Parametrised successor to the single-cycle opcode decoder. It accepts instruction words over a valid/ready handshake and decodes opcode plus argument field. It sequences single- and multi-cycle operations (pipelined MAC, counted WAIT, indexed register set) and drives registered control strobes to the ALU datapath. It sits between instruction fetch and the ALU register bank.

Parameters:
OPCODE_WIDTH, 3, opcode field width (instr MSBs)
ARG_WIDTH, 8, argument field width (instr LSBs); also width of the internal cycle counter
NUM_REGS, 5, number of ALU registers; width of alu_reg_en
MAC_LATENCY, 3, MAC duration in cycles (>=1)
RES_MASK, 5'b00101, alu_reg_en pattern for result write (regs C, A); width NUM_REGS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word valid
instr  in  OPCODE_WIDTH+ARG_WIDTH  {opcode, arg}
instr_ready  out  1  sequencer can accept an instruction this cycle
f_add  out  1  ALU add mode
f_mac  out  1  ALU MAC mode; held for the whole MAC
f_wait  out  1  ALU idle/wait
wr_res  out  1  write ALU result
alu_reg_en  out  NUM_REGS  per-register load enable
busy  out  1  an operation is executing
illegal_op  out  1  one-cycle pulse on an undefined opcode or out-of-range register index

Behaviour:
- Opcodes: ADD=0, MAC=1, WAIT=2, SETR=3, NOP=4. Values 5..7 are illegal.
- State: IDLE / EXEC, plus down-counter cnt (ARG_WIDTH bits) and a latched opcode. All outputs except instr_ready are registered.
- Accept: instr_valid && instr_ready at edge T. The op's outputs appear in cycle T+1 and last for the op's duration D.
- instr_ready = (state==IDLE) || (state==EXEC && cnt==1). Back-to-back issue has no bubble; the next op's outputs start the cycle after the last cycle of the current op.
- If the last cycle completes with no new accept, go to IDLE. All strobes are 0 and busy=0 from the next cycle.
- ADD: D=1. f_add=1, wr_res=1, alu_reg_en=RES_MASK.
- MAC: D=MAC_LATENCY. f_mac=1 in all D cycles. wr_res=1 and alu_reg_en=RES_MASK only in the final cycle; otherwise both are 0.
- WAIT: D=arg, with arg=0 treated as D=1. f_wait=1 in all D cycles. Other strobes are 0.
- SETR: D=1. alu_reg_en = one-hot bit arg if arg<NUM_REGS.
  - If arg>=NUM_REGS: alu_reg_en=0 and illegal_op=1 for that cycle.
- NOP: D=1. All strobes are 0, busy=1.
- Illegal opcode: D=1. illegal_op=1, all other strobes 0, busy=1. The instruction is consumed; no hang.
- busy=1 in every EXEC cycle.
- Strobes are mutually exclusive: at most one of f_add/f_mac/f_wait is high in any cycle.
- Counter: loaded with D on accept and decremented each EXEC cycle. It never underflows; a reload at cnt==1 takes priority over the decrement.
- instr is sampled only on handshake. Changes to instr while instr_ready=0 have no effect.
- Reset (asynchronous, any time including mid-MAC/WAIT):
  - state=IDLE, cnt=0.
  - All registered outputs = 0 immediately; instr_ready=1 once reset is released.
  - The in-flight op is discarded with no wr_res.

Test Plan:
- Reset, then ADD at T -> in cycle T+1: f_add=1, wr_res=1, alu_reg_en=00101, busy=1. Cycle T+2: all 0, instr_ready=1.
- MAC (MAC_LATENCY=3) accepted at T -> f_mac=1 in T+1..T+3. wr_res=1 and alu_reg_en=00101 only in T+3. instr_ready=0 in T+1..T+2 and 1 in T+3.
- WAIT arg=5 followed by valid ADD held throughout -> f_wait in 5 consecutive cycles, then f_add in the next cycle with no gap. Then WAIT arg=0 -> f_wait for exactly 1 cycle.
- SETR arg=3 -> alu_reg_en=01000 for 1 cycle. SETR arg=7 -> alu_reg_en=0 and illegal_op=1 for 1 cycle. Opcode 6 -> illegal_op=1, busy=1 for 1 cycle, then ready.
- rst_n low in the 2nd cycle of MAC -> all outputs 0 immediately and no wr_res pulse. After release, ADD executes normally.
- Random stream (mixed ops, random instr_valid gaps) vs reference model -> per-cycle output match, one-hot mode strobes, handshake count equals completed-op count.
